// File: rtl/mmaps_pkg.sv
// Shared definitions for the channel readout packer: frame tags, FSM encoding
// and the 16-bit frame word builder.
package mmaps_pkg;

    localparam logic [3:0] TAG_HDR  = 4'hA;
    localparam logic [3:0] TAG_CSUM = 4'hC;
    localparam logic [3:0] TAG_TRL  = 4'hE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        CAPT  = 3'd2,
        CSUM  = 3'd3,
        TRAIL = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } state_t;

    function automatic logic [15:0] frame_word(input logic [3:0] tag, input logic [11:0] payload);
        return {tag, payload};
    endfunction

endpackage

// File: rtl/packer_fifo.sv
// Synchronous first-word-fall-through FIFO, 16-bit words, depth 2^AW.
// A pop in the same cycle as a push into a full FIFO frees the slot first.
module packer_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [15:0]   wr_data,
    input  logic          pop,
    output logic [15:0]   rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == DEPTH_L);
    assign level   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Empty head reads as zero so out_data is clean after reset and between frames.
    assign rd_data = empty ? 16'h0 : mem[rd_ptr];

endmodule

// File: rtl/channel_readout_packer.sv
// Requests a channel readout, captures its sample stream and frames it as
// header / samples / [checksum] / trailer words. Checksum word when CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | read_request raised, header pushed
// CAPT  | capturing samples while channel streams
// CSUM  | pushing xor checksum word (CHECKSUM_EN only)
// TRAIL | pushing trailer with sample count
// DRAIN | waiting for consumer to take every word
// DONE  | one-cycle spi_done pulse
module channel_readout_packer
    import mmaps_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int SIZE    = 12,
    parameter int CH_W    = 4,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CH_W-1:0]  chan_id,
    output logic             read_request,
    input  logic             sc_ro_enable,
    input  logic             sc_rodone_n,
    input  logic [WIDTH-1:0] sc_data,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             spi_done,
    output logic             busy,
    output logic             overflow
);

    state_t            state;
    state_t            state_nx;
    logic [CH_W-1:0]   chan_q;
    logic [SIZE-1:0]   count_q;
    logic              ovf_q;
`ifdef CHECKSUM_EN
    logic [11:0]       csum_q;
`endif

    logic              push;
    logic [15:0]       push_data;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_level;
    logic              room;
    logic              sample_in;
    logic [11:0]       sample;

    assign sample    = 12'(sc_data);
    assign pop       = out_valid && out_ready;
    assign room      = !fifo_full || pop;
    assign sample_in = (state == CAPT) && sc_ro_enable && sc_rodone_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_data = 16'h0;
        case (state)
            IDLE: begin
                if (start) state_nx = REQ;
            end
            REQ: begin
                push      = 1'b1;
                push_data = frame_word(TAG_HDR, {chan_q[3:0], 8'h00});
                if (room) state_nx = CAPT;
            end
            CAPT: begin
                if (!sc_rodone_n) begin
`ifdef CHECKSUM_EN
                    state_nx = CSUM;
`else
                    state_nx = TRAIL;
`endif
                end else if (sc_ro_enable) begin
                    push      = 1'b1;
                    push_data = frame_word(chan_q[3:0], sample);
                end
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                push      = 1'b1;
                push_data = frame_word(TAG_CSUM, csum_q);
                if (room) state_nx = TRAIL;
            end
`endif
            TRAIL: begin
                push      = 1'b1;
                push_data = frame_word(TAG_TRL, 12'(count_q));
                if (room) state_nx = DRAIN;
            end
            DRAIN: begin
                // Leave as the trailer is taken so spi_done follows acceptance by one cycle.
                if (fifo_empty || (fifo_level == (FIFO_AW+1)'(1) && pop)) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else if (state == IDLE && start) begin
            chan_q  <= chan_id;
            count_q <= '0;
            ovf_q   <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else if (sample_in) begin
            if (room) begin
                if (count_q != '1) count_q <= count_q + SIZE'(1);
`ifdef CHECKSUM_EN
                csum_q <= csum_q ^ sample;
`endif
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

    packer_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (push_data),
        .pop     (pop),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_valid    = !fifo_empty;
    assign read_request = (state == REQ) || (state == CAPT) || (state == CSUM) ||
                          (state == TRAIL) || (state == DRAIN);
    assign busy         = (state != IDLE);
    assign spi_done     = (state == DONE);
    assign overflow     = ovf_q;

endmodule
